// File: rtl/boot_shadow_loader.sv
// boot_shadow_loader: copies a fixed window of boot ROM words into the shadow RAM
// and holds the CPU core in reset until the whole image is in place. It also keeps a
// running additive checksum of every word written during the current pass.
module boot_shadow_loader #(
   parameter int unsigned     AW    = 8,
   parameter int unsigned     DW    = 16,
   parameter logic [AW-1:0]   START = AW'('hdf),
   parameter logic [AW-1:0]   END   = AW'('hfd)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          cpu_reset,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] checksum
);

   localparam logic [0:0] LOAD = 1'b0;
   localparam logic [0:0] DONE = 1'b1;

   logic [0:0]    state;
   logic [AW-1:0] ptr;

   // The ROM is addressed straight from the registered pointer, so no input reaches it combinationally.
   assign rom_addr = ptr;

   // Copy engine: one ROM word is latched into the RAM write port per cycle while loading.
   // The pointer stops at END instead of incrementing, so END at the top of the address
   // space never wraps. A restart is only accepted once done is already showing, which
   // guarantees done is visible for at least one cycle even if start is held throughout.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LOAD;
         ptr       <= START;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b1;
         done      <= 1'b0;
         checksum  <= '0;
      end else begin
         case (state)
            LOAD: begin
               ram_we    <= 1'b1;
               ram_addr  <= ptr;
               ram_wdata <= rom_data;
               checksum  <= checksum + rom_data;
               if (ptr == END) begin
                  state <= DONE;
                  ptr   <= START;
               end else begin
                  ptr <= ptr + AW'(1);
               end
            end
            default: begin
               ram_we <= 1'b0;
               if (start && done) begin
                  state     <= LOAD;
                  ptr       <= START;
                  cpu_reset <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  checksum  <= '0;
               end else begin
                  cpu_reset <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boot_shadow_loader.sv
// tb_boot_shadow_loader: scoreboard bench for the shadow loader. Expected RAM writes
// are queued when a pass is launched and popped by a monitor as the writes appear.
module tb_boot_shadow_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic        cpu_reset, busy, done;
   logic [15:0] checksum;

   logic        reset1 = 1'b1;
   logic [7:0]  rom1_addr;
   logic [15:0] rom1_data;
   logic        ram1_we;
   logic [7:0]  ram1_addr;
   logic [15:0] ram1_wdata;
   logic        cpu1_reset, busy1, done1;
   logic [15:0] checksum1;

   int          checks = 0;
   int          failures = 0;
   int          writes = 0;
   int          rom_mode = 0;
   bit          mon_en = 1'b0;
   logic [23:0] exp_q[$];
   logic [23:0] mon_exp;
   logic [15:0] exp_sum;

   always #5 clk = ~clk;

   boot_shadow_loader dut (
      .clk(clk), .reset(reset), .start(start),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .checksum(checksum)
   );

   boot_shadow_loader #(.START(8'h40), .END(8'h40)) u_one (
      .clk(clk), .reset(reset1), .start(1'b0),
      .rom_addr(rom1_addr), .rom_data(rom1_data),
      .ram_we(ram1_we), .ram_addr(ram1_addr), .ram_wdata(ram1_wdata),
      .cpu_reset(cpu1_reset), .busy(busy1), .done(done1), .checksum(checksum1)
   );

   function automatic logic [15:0] real_word(input logic [7:0] a);
      case (a)
         8'hdf:   real_word = 16'h00a2;
         8'hfc:   real_word = 16'hffdf;
         8'hfd:   real_word = 16'hffff;
         default: real_word = {a ^ 8'h5a, a};
      endcase
   endfunction

   // Bench ROM: either the address pattern or a boot image that is X outside the window.
   always_comb begin
      if (rom_mode == 0) rom_data = {8'h00, rom_addr};
      else if (rom_addr >= 8'hdf && rom_addr <= 8'hfd) rom_data = real_word(rom_addr);
      else rom_data = 16'hxxxx;
   end

   // ROM for the single-word instance.
   always_comb rom1_data = {8'h00, rom1_addr};

   // Write monitor and invariants, sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ram_we === 1'b1) begin
            writes++;
            checks++;
            if (^ram_wdata === 1'bx) begin
               failures++;
               $display("[TB] FAIL wdata_x: got %h, required no X", ram_wdata);
            end
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_write: got addr %h data %h, required no write", ram_addr, ram_wdata);
            end else begin
               mon_exp = exp_q.pop_front();
               if ({ram_addr, ram_wdata} !== mon_exp)
                  begin
                     failures++;
                     $display("[TB] FAIL write_seq: got %h/%h, required %h/%h", ram_addr, ram_wdata, mon_exp[23:16], mon_exp[15:0]);
                  end
            end
         end
         checks++;
         if (busy !== ~done) begin
            failures++;
            $display("[TB] FAIL busy_vs_done: got busy %b done %b, required busy==~done", busy, done);
         end
         checks++;
         if (done === 1'b1 && cpu_reset === 1'b1) begin
            failures++;
            $display("[TB] FAIL done_and_cpu_reset: got both 1, required not both high");
         end
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push_pass(input int mode, input int count);
      logic [7:0] a;
      exp_sum = 16'h0000;
      for (int i = 0; i < count; i++) begin
         a = 8'hdf + 8'(i);
         if (mode == 0) begin
            exp_q.push_back({a, 8'h00, a});
            exp_sum = exp_sum + {8'h00, a};
         end else begin
            exp_q.push_back({a, real_word(a)});
            exp_sum = exp_sum + real_word(a);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      wait_edges(2);
      checks++;
      if ({ram_we, cpu_reset, busy, done} !== 4'b0110) begin
         failures++;
         $display("[TB] FAIL reset_flags: got we/cr/busy/done %b, required 0110", {ram_we, cpu_reset, busy, done});
      end
      checks++;
      if ({checksum, ram_addr, ram_wdata, rom_addr} !== {16'h0000, 8'h00, 16'h0000, 8'hdf}) begin
         failures++;
         $display("[TB] FAIL reset_values: got sum %h addr %h wdata %h rom_addr %h, required 0000 00 0000 df",
                  checksum, ram_addr, ram_wdata, rom_addr);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_default_copy;
      rom_mode = 0;
      writes = 0;
      push_pass(0, 31);
      reset = 1'b0;
      wait_edges(31);
      checks++;
      if ({cpu_reset, done} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL edge31_hold: got cpu_reset/done %b, required 10", {cpu_reset, done});
      end
      wait_edges(1);
      checks++;
      if ({cpu_reset, done, busy} !== 3'b010) begin
         failures++;
         $display("[TB] FAIL edge32_release: got cpu_reset/done/busy %b, required 010", {cpu_reset, done, busy});
      end
      checks++;
      if (checksum !== 16'h1cd2) begin
         failures++;
         $display("[TB] FAIL checksum_default: got %h, required 1cd2", checksum);
      end
      checks++;
      if (writes != 31 || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL write_count: got %0d writes, %0d pending, required 31 and 0", writes, exp_q.size());
      end
      wait_edges(5);
      checks++;
      if ({checksum, ram_we, done} !== {16'h1cd2, 1'b0, 1'b1}) begin
         failures++;
         $display("[TB] FAIL done_stable: got sum %h we %b done %b, required 1cd2 0 1", checksum, ram_we, done);
      end
   endtask

   task automatic test_restart_pulse;
      writes = 0;
      start = 1'b1;
      wait_edges(1);
      start = 1'b0;
      checks++;
      if ({cpu_reset, done, busy, checksum} !== {3'b101, 16'h0000}) begin
         failures++;
         $display("[TB] FAIL restart_enter: got cr/done/busy %b sum %h, required 101 0000", {cpu_reset, done, busy}, checksum);
      end
      push_pass(0, 31);
      wait_edges(31);
      checks++;
      if (cpu_reset !== 1'b1) begin
         failures++;
         $display("[TB] FAIL restart_edge31: got cpu_reset %b, required 1", cpu_reset);
      end
      wait_edges(1);
      checks++;
      if ({done, cpu_reset, checksum} !== {2'b10, 16'h1cd2} || writes != 31) begin
         failures++;
         $display("[TB] FAIL restart_done: got done %b cr %b sum %h writes %0d, required 1 0 1cd2 31",
                  done, cpu_reset, checksum, writes);
      end
   endtask

   task automatic test_start_held;
      writes = 0;
      start = 1'b1;
      wait_edges(1);
      push_pass(0, 31);
      wait_edges(31);
      checks++;
      if ({cpu_reset, busy} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL held_loading: got cr/busy %b, required 11", {cpu_reset, busy});
      end
      wait_edges(1);
      checks++;
      if ({done, cpu_reset} !== 2'b10 || writes != 31 || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL held_single_pass: got done %b cr %b writes %0d, required 1 0 31", done, cpu_reset, writes);
      end
      wait_edges(1);
      start = 1'b0;
      checks++;
      if ({done, cpu_reset} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL held_retrigger: got done/cr %b, required 01", {done, cpu_reset});
      end
      push_pass(0, 31);
      wait_edges(32);
      checks++;
      if ({done, checksum} !== {1'b1, 16'h1cd2}) begin
         failures++;
         $display("[TB] FAIL held_second_pass: got done %b sum %h, required 1 1cd2", done, checksum);
      end
   endtask

   task automatic test_reset_midcopy;
      start = 1'b1;
      wait_edges(1);
      start = 1'b0;
      push_pass(0, 10);
      wait_edges(10);
      reset = 1'b1;
      wait_edges(1);
      checks++;
      if ({ram_we, cpu_reset, busy, done, checksum} !== {4'b0110, 16'h0000} || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL midcopy_reset: got we/cr/busy/done %b sum %h pending %0d, required 0110 0000 0",
                  {ram_we, cpu_reset, busy, done}, checksum, exp_q.size());
      end
      push_pass(0, 31);
      reset = 1'b0;
      wait_edges(1);
      checks++;
      if ({ram_we, ram_addr} !== {1'b1, 8'hdf}) begin
         failures++;
         $display("[TB] FAIL midcopy_restart: got we %b addr %h, required 1 df", ram_we, ram_addr);
      end
      wait_edges(31);
      checks++;
      if ({done, checksum} !== {1'b1, 16'h1cd2}) begin
         failures++;
         $display("[TB] FAIL midcopy_done: got done %b sum %h, required 1 1cd2", done, checksum);
      end
   endtask

   task automatic test_real_rom;
      reset = 1'b1;
      rom_mode = 1;
      wait_edges(1);
      push_pass(1, 31);
      reset = 1'b0;
      wait_edges(1);
      checks++;
      if ({ram_addr, ram_wdata} !== {8'hdf, 16'h00a2}) begin
         failures++;
         $display("[TB] FAIL real_first: got %h/%h, required df/00a2", ram_addr, ram_wdata);
      end
      wait_edges(31);
      checks++;
      if ({done, checksum} !== {1'b1, exp_sum} || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL real_checksum: got done %b sum %h, required 1 %h", done, checksum, exp_sum);
      end
   endtask

   task automatic test_single_word;
      reset1 = 1'b0;
      wait_edges(1);
      checks++;
      if ({ram1_we, ram1_addr, ram1_wdata, cpu1_reset} !== {1'b1, 8'h40, 16'h0040, 1'b1}) begin
         failures++;
         $display("[TB] FAIL single_write: got we %b %h/%h cr %b, required 1 40/0040 1",
                  ram1_we, ram1_addr, ram1_wdata, cpu1_reset);
      end
      wait_edges(1);
      checks++;
      if ({ram1_we, cpu1_reset, done1, checksum1} !== {3'b001, 16'h0040}) begin
         failures++;
         $display("[TB] FAIL single_done: got we/cr/done %b sum %h, required 001 0040",
                  {ram1_we, cpu1_reset, done1}, checksum1);
      end
   endtask

   initial begin
      test_reset();
      test_default_copy();
      test_restart_pulse();
      test_start_held();
      test_reset_midcopy();
      test_real_rom();
      test_single_word();
      wait_edges(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
